// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multi-cycle RV32I-subset datapath. It walks each
//   instruction through fetch, decode, execute, memory and write-back. It
//   drives the datapath enables and mux selects, and it waits on a
//   single-signal memory ready handshake. It also raises a sticky
//   illegal-opcode flag and counts retired instructions.
//
// Ports
//   clk          system clock (rising edge)
//   reset        synchronous, active-high
//   InstCode     instruction register contents
//   Zero         ALU result == 0
//   MemReady     memory completes the current read/write this cycle
//   PCWrite      PC load enable
//   PCSrc        PC source: 0 = ALU result, 1 = ALUOut
//   IRWrite      IR load enable (also latches OldPC)
//   MemRead      memory read request
//   MemWrite     memory write request
//   IorD         memory address: 0 = PC, 1 = ALUOut
//   RegWrite     register file write enable
//   MemToReg     write-back data: 0 = ALUOut, 1 = memory data register
//   ALUSrcA      0 = PC, 1 = rs1, 2 = zero, 3 = OldPC
//   ALUSrcB      0 = rs2, 1 = constant 4, 2 = immediate
//   ALUOp        00 add, 01 subtract, 10 decode funct3/funct7
//   IllegalInst  sticky illegal-opcode flag
//   RetireCount  retired-instruction counter (wraps)
//   State        current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstCode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        IllegalInst,
    output logic [31:0] RetireCount,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        EXEC_U = 4'd8,
        ALUWB  = 4'd9,
        BRANCH = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state, state_n;
    logic [6:0]  opcode;
    logic        retire;

    // Only the opcode and funct3[0] steer the sequencing; the rest of the
    // word is consumed by the datapath.
    logic unused_inst;
    assign unused_inst = ^{InstCode[31:13], InstCode[11:7]};

    assign opcode = InstCode[6:0];
    assign State  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            IllegalInst <= 1'b0;
            RetireCount <= 32'd0;
        end else begin
            state <= state_n;
            if (state_n == TRAP)
                IllegalInst <= 1'b1;
            if (retire)
                RetireCount <= RetireCount + 32'd1;
        end
    end

    always_comb begin
        state_n  = state;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        ALUOp    = 2'b00;
        retire   = 1'b0;

        unique case (state)
            FETCH: begin
                // ALU computes PC+4 while memory returns the instruction.
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                // Branch target OldPC + imm lands in ALUOut speculatively.
                ALUSrcA = 2'd3;
                ALUSrcB = 2'd2;
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_n = MEMADR;
                    OP_RTYPE:          state_n = EXEC_R;
                    OP_ITYPE:          state_n = EXEC_I;
                    OP_AUIPC, OP_LUI:  state_n = EXEC_U;
                    OP_BRANCH:         state_n = BRANCH;
                    default:           state_n = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                state_n = (opcode == OP_STORE) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)
                    state_n = MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_n  = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end
            end
            EXEC_R: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd0;
                ALUOp   = 2'b10;
                state_n = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp   = 2'b10;
                state_n = ALUWB;
            end
            EXEC_U: begin
                // PC has already advanced, so AUIPC adds to OldPC; LUI adds to zero.
                ALUSrcA = (opcode == OP_AUIPC) ? 2'd3 : 2'd2;
                ALUSrcB = 2'd2;
                state_n = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_n  = FETCH;
            end
            BRANCH: begin
                // funct3[0] selects beq (take on equal) vs bne (take on not-equal).
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd0;
                ALUOp   = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = Zero ^ InstCode[12];
                retire  = 1'b1;
                state_n = FETCH;
            end
            TRAP: begin
                state_n = TRAP;
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // A reset cycle must never commit architectural state.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule
